// File: rtl/flash_loader_if.sv
// Byte-stream input and flash write port of the program loader.
// The loader takes the master modport; the stream source and memory take slave.
interface flash_loader_if #(
  parameter int WIDTH = 32
);
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             flash_en;
  logic [WIDTH-1:0] flash_addr;
  logic [WIDTH-1:0] flash_data;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output flash_en,
    output flash_addr,
    output flash_data
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  flash_en,
    input  flash_addr,
    input  flash_data
  );
endinterface

// File: rtl/flash_loader.sv
// Length-prefixed byte-stream program loader; holds the core in reset while loading.
// Optional trailing XOR checksum byte: define FLASH_LOADER_CHECKSUM_EN.
module flash_loader #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR = '0,
  parameter int               MAX_WORDS = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  flash_loader_if.master bus,
  output logic           core_rst,
  output logic           done,
  output logic           error
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
`ifdef FLASH_LOADER_CHECKSUM_EN
    CSUM = 3'd3,
`endif
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

`ifdef FLASH_LOADER_CHECKSUM_EN
  localparam state_t END_ST = CSUM;
`else
  localparam state_t END_ST = DONE;
`endif

  localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MAX_WORDS);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] widx;
  logic [WIDTH-1:0] hdr_val;
  logic             ready;
  logic             accept;
  logic             last_byte;
  logic             last_word;
  logic             restart;
`ifdef FLASH_LOADER_CHECKSUM_EN
  logic [7:0]       xsum;
`endif

  // Bytes enter at the top so the 4th byte lands as the MSB.
  assign hdr_val   = {bus.byte_data, sr[WIDTH-1:8]};
  assign accept    = bus.byte_valid & ready;
  assign last_byte = accept & (cnt == 2'd3);
  assign last_word = (widx == n - WIDTH'(1));
  assign restart   = start & ((state == IDLE) |
                              (state == DONE) |
                              (state == ERR));

  always_comb begin
    ready    = 1'b0;
    core_rst = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state)
      HDR:  ready = 1'b1;
      DATA: ready = 1'b1;
`ifdef FLASH_LOADER_CHECKSUM_EN
      CSUM: ready = 1'b1;
`endif
      DONE: begin
        core_rst = 1'b0;
        done     = 1'b1;
      end
      ERR:  error = 1'b1;
      default: ;
    endcase
  end

  assign bus.byte_ready = ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = HDR;
      HDR: begin
        if (last_byte) begin
          if (hdr_val > MAX_N)
            state_nxt = ERR;
          else if (hdr_val == '0)
            state_nxt = END_ST;
          else
            state_nxt = DATA;
        end
      end
      DATA: if (last_byte && last_word) state_nxt = END_ST;
`ifdef FLASH_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept)
          state_nxt = (bus.byte_data == xsum) ? DONE : ERR;
      end
`endif
      DONE: if (start) state_nxt = HDR;
      ERR:  if (start) state_nxt = HDR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      sr             <= '0;
      n              <= '0;
      widx           <= '0;
      bus.flash_en   <= 1'b0;
      bus.flash_addr <= BASE_ADDR;
      bus.flash_data <= '0;
    end else begin
      bus.flash_en <= 1'b0;
      if (restart) begin
        cnt  <= '0;
        widx <= '0;
      end
      if (accept) begin
        cnt <= cnt + 2'd1;
        sr  <= hdr_val;
      end
      if (last_byte && state == HDR)
        n <= hdr_val;
      // Address wraps modulo 2^WIDTH by plain truncation.
      if (last_byte && state == DATA) begin
        bus.flash_en   <= 1'b1;
        bus.flash_data <= hdr_val;
        bus.flash_addr <= BASE_ADDR + {widx[WIDTH-3:0], 2'b00};
        widx           <= widx + WIDTH'(1);
      end
    end
  end

`ifdef FLASH_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || restart)
      xsum <= '0;
    else if (accept && (state == HDR || state == DATA))
      xsum <= xsum ^ bus.byte_data;
  end
`endif

endmodule
